// File: rtl/definitions_pkg.sv
// Shared decode definitions: opcode encodings, register address width and
// the execute-stage control bundle.
package definitions_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic reg_we;
    logic mem_rd;
    logic mem_wr;
    logic branch;
  } idex_ctrl_t;

endpackage

// File: rtl/register_file.sv
// 2-read/1-write register file; R0 is hard-wired to zero and a same-cycle
// write is forwarded to the read ports.
module register_file
  import definitions_pkg::*;
#(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0]     rs_data_o,
  output logic [DATA_W-1:0]     rt_data_o,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rs_data_o = '0;
    rt_data_o = '0;
    if (rs_addr_i != '0) rs_data_o = (we_i && (waddr_i == rs_addr_i)) ? wdata_i : regs_q[rs_addr_i];
    if (rt_addr_i != '0) rt_data_o = (we_i && (waddr_i == rt_addr_i)) ? wdata_i : regs_q[rt_addr_i];
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// Decode stage: IF/ID capture, instruction decode, register read, load-use
// hazard detection and the registered ID/EX bundle for execute.
module instruction_decode_stage
  import definitions_pkg::*;
#(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           if_instr_i,
  input  logic [DATA_W-1:0]     if_pc_i,
  input  logic                  flush_i,
  input  logic                  wb_we_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  output logic                  pc_stall_o,
  output logic                  idex_valid_o,
  output logic [DATA_W-1:0]     idex_pc_o,
  output logic [5:0]            idex_opcode_o,
  output logic [5:0]            idex_funct_o,
  output logic [DATA_W-1:0]     idex_rs_data_o,
  output logic [DATA_W-1:0]     idex_rt_data_o,
  output logic [REG_ADDR_W-1:0] idex_rs_o,
  output logic [REG_ADDR_W-1:0] idex_rt_o,
  output logic [REG_ADDR_W-1:0] idex_dst_o,
  output logic [DATA_W-1:0]     idex_imm_o,
  output logic                  idex_reg_we_o,
  output logic                  idex_mem_rd_o,
  output logic                  idex_mem_wr_o,
  output logic                  idex_branch_o
);

  logic                  ifid_valid_q;
  logic [DATA_W-1:0]     ifid_pc_q;
  logic [31:0]           ifid_instr_q;

  logic [5:0]            dec_opcode;
  logic [REG_ADDR_W-1:0] dec_rs, dec_rt, dec_dst;
  logic [DATA_W-1:0]     dec_imm, rs_data, rt_data;
  idex_ctrl_t            dec_ctrl;
  logic                  hazard, bubble;

  logic                  idex_valid_q, idex_valid_d;
  logic [DATA_W-1:0]     idex_pc_q, idex_pc_d;
  logic [5:0]            idex_opcode_q, idex_opcode_d, idex_funct_q, idex_funct_d;
  logic [DATA_W-1:0]     idex_rs_data_q, idex_rs_data_d, idex_rt_data_q, idex_rt_data_d;
  logic [REG_ADDR_W-1:0] idex_rs_q, idex_rs_d, idex_rt_q, idex_rt_d, idex_dst_q, idex_dst_d;
  logic [DATA_W-1:0]     idex_imm_q, idex_imm_d;
  idex_ctrl_t            idex_ctrl_q, idex_ctrl_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
    end else begin
      if (flush_i)         ifid_valid_q <= 1'b0;
      else if (!pc_stall_o) ifid_valid_q <= 1'b1;
      if (!pc_stall_o) begin
        ifid_pc_q    <= if_pc_i;
        ifid_instr_q <= if_instr_i;
      end
    end
  end

  assign dec_opcode = ifid_instr_q[31:26];
  assign dec_rs     = ifid_instr_q[25:21];
  assign dec_rt     = ifid_instr_q[20:16];
  assign dec_imm    = {{(DATA_W-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};

  always_comb begin
    dec_ctrl = '0;
    dec_dst  = '0;
    case (dec_opcode)
      OP_RTYPE: begin
        dec_dst         = ifid_instr_q[15:11];
        dec_ctrl.reg_we = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        dec_dst         = dec_rt;
        dec_ctrl.reg_we = 1'b1;
      end
      OP_LW: begin
        dec_dst         = dec_rt;
        dec_ctrl.reg_we = 1'b1;
        dec_ctrl.mem_rd = 1'b1;
      end
      OP_SW:   dec_ctrl.mem_wr = 1'b1;
      OP_BEQ:  dec_ctrl.branch = 1'b1;
      default: ;
    endcase
  end

  register_file #(
    .REG_COUNT (REG_COUNT),
    .DATA_W    (DATA_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rs_addr_i (dec_rs),
    .rt_addr_i (dec_rt),
    .rs_data_o (rs_data),
    .rt_data_o (rt_data),
    .we_i      (wb_we_i),
    .waddr_i   (wb_addr_i),
    .wdata_i   (wb_data_i)
  );

  // Compared against both rs and rt regardless of format, so an I-type whose
  // rt is its destination may stall conservatively.
  assign hazard = idex_valid_q && idex_ctrl_q.mem_rd && (idex_dst_q != '0) && ifid_valid_q &&
                  ((idex_dst_q == dec_rs) || (idex_dst_q == dec_rt));
  assign pc_stall_o = hazard && !flush_i;
  assign bubble     = flush_i || hazard || !ifid_valid_q;

  always_comb begin
    idex_valid_d   = 1'b0;
    idex_pc_d      = '0;
    idex_opcode_d  = '0;
    idex_funct_d   = '0;
    idex_rs_data_d = '0;
    idex_rt_data_d = '0;
    idex_rs_d      = '0;
    idex_rt_d      = '0;
    idex_dst_d     = '0;
    idex_imm_d     = '0;
    idex_ctrl_d    = '0;
    if (!bubble) begin
      idex_valid_d   = 1'b1;
      idex_pc_d      = ifid_pc_q;
      idex_opcode_d  = dec_opcode;
      idex_funct_d   = ifid_instr_q[5:0];
      idex_rs_data_d = rs_data;
      idex_rt_data_d = rt_data;
      idex_rs_d      = dec_rs;
      idex_rt_d      = dec_rt;
      idex_dst_d     = dec_dst;
      idex_imm_d     = dec_imm;
      idex_ctrl_d    = dec_ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_valid_q   <= 1'b0;
      idex_pc_q      <= '0;
      idex_opcode_q  <= '0;
      idex_funct_q   <= '0;
      idex_rs_data_q <= '0;
      idex_rt_data_q <= '0;
      idex_rs_q      <= '0;
      idex_rt_q      <= '0;
      idex_dst_q     <= '0;
      idex_imm_q     <= '0;
      idex_ctrl_q    <= '0;
    end else begin
      idex_valid_q   <= idex_valid_d;
      idex_pc_q      <= idex_pc_d;
      idex_opcode_q  <= idex_opcode_d;
      idex_funct_q   <= idex_funct_d;
      idex_rs_data_q <= idex_rs_data_d;
      idex_rt_data_q <= idex_rt_data_d;
      idex_rs_q      <= idex_rs_d;
      idex_rt_q      <= idex_rt_d;
      idex_dst_q     <= idex_dst_d;
      idex_imm_q     <= idex_imm_d;
      idex_ctrl_q    <= idex_ctrl_d;
    end
  end

  assign idex_valid_o   = idex_valid_q;
  assign idex_pc_o      = idex_pc_q;
  assign idex_opcode_o  = idex_opcode_q;
  assign idex_funct_o   = idex_funct_q;
  assign idex_rs_data_o = idex_rs_data_q;
  assign idex_rt_data_o = idex_rt_data_q;
  assign idex_rs_o      = idex_rs_q;
  assign idex_rt_o      = idex_rt_q;
  assign idex_dst_o     = idex_dst_q;
  assign idex_imm_o     = idex_imm_q;
  assign idex_reg_we_o  = idex_ctrl_q.reg_we;
  assign idex_mem_rd_o  = idex_ctrl_q.mem_rd;
  assign idex_mem_wr_o  = idex_ctrl_q.mem_wr;
  assign idex_branch_o  = idex_ctrl_q.branch;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage; expected values are hand-computed
// from the instruction encodings driven.
module tb_instruction_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_instr, if_pc, wb_data;
  logic        flush, wb_we;
  logic [4:0]  wb_addr;
  logic        pc_stall_o, idex_valid_o;
  logic [31:0] idex_pc_o, idex_rs_data_o, idex_rt_data_o, idex_imm_o;
  logic [5:0]  idex_opcode_o, idex_funct_o;
  logic [4:0]  idex_rs_o, idex_rt_o, idex_dst_o;
  logic        idex_reg_we_o, idex_mem_rd_o, idex_mem_wr_o, idex_branch_o;
  logic [3:0]  ctrl;

  int checks = 0;
  int failures = 0;

  assign ctrl = {idex_reg_we_o, idex_mem_rd_o, idex_mem_wr_o, idex_branch_o};

  always #5 clk = ~clk;

  instruction_decode_stage #(.REG_COUNT(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_instr_i     (if_instr),
    .if_pc_i        (if_pc),
    .flush_i        (flush),
    .wb_we_i        (wb_we),
    .wb_addr_i      (wb_addr),
    .wb_data_i      (wb_data),
    .pc_stall_o     (pc_stall_o),
    .idex_valid_o   (idex_valid_o),
    .idex_pc_o      (idex_pc_o),
    .idex_opcode_o  (idex_opcode_o),
    .idex_funct_o   (idex_funct_o),
    .idex_rs_data_o (idex_rs_data_o),
    .idex_rt_data_o (idex_rt_data_o),
    .idex_rs_o      (idex_rs_o),
    .idex_rt_o      (idex_rt_o),
    .idex_dst_o     (idex_dst_o),
    .idex_imm_o     (idex_imm_o),
    .idex_reg_we_o  (idex_reg_we_o),
    .idex_mem_rd_o  (idex_mem_rd_o),
    .idex_mem_wr_o  (idex_mem_wr_o),
    .idex_branch_o  (idex_branch_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    fetch(32'h0, 32'h0);
    #2;
    checks++; if (idex_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", idex_valid_o); end
    checks++; if (pc_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", pc_stall_o); end
    checks++; if (ctrl !== 4'b0000) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000", ctrl); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_addi();
    fetch(32'h20030007, 32'h10);
    tick();
    fetch(32'h0, 32'h14);
    tick();
    checks++; if (idex_valid_o !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0h exp=1", idex_valid_o); end
    checks++; if (idex_dst_o !== 5'd3) begin failures++; $display("FAIL addi_dst got=%0d exp=3", idex_dst_o); end
    checks++; if (idex_imm_o !== 32'h7) begin failures++; $display("FAIL addi_imm got=%h exp=00000007", idex_imm_o); end
    checks++; if (ctrl !== 4'b1000) begin failures++; $display("FAIL addi_ctrl got=%b exp=1000", ctrl); end
    checks++; if (idex_pc_o !== 32'h10) begin failures++; $display("FAIL addi_pc got=%h exp=00000010", idex_pc_o); end
    checks++; if (idex_opcode_o !== 6'h08) begin failures++; $display("FAIL addi_opcode got=%h exp=08", idex_opcode_o); end
  endtask

  task automatic test_sign_ext();
    fetch(32'h2001FFFC, 32'h40);
    tick();
    fetch(32'h0, 32'h44);
    tick();
    checks++; if (idex_imm_o !== 32'hFFFFFFFC) begin failures++; $display("FAIL sext_imm got=%h exp=fffffffc", idex_imm_o); end
    checks++; if (idex_dst_o !== 5'd1) begin failures++; $display("FAIL sext_dst got=%0d exp=1", idex_dst_o); end
  endtask

  task automatic test_bypass();
    fetch(32'h00802820, 32'h50);
    tick();
    wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'hDEADBEEF;
    tick();
    wb_we = 1'b0;
    checks++; if (idex_rs_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_rs got=%h exp=deadbeef", idex_rs_data_o); end
    checks++; if (idex_dst_o !== 5'd5) begin failures++; $display("FAIL bypass_dst got=%0d exp=5", idex_dst_o); end
    tick();
    checks++; if (idex_rs_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL stored_rs got=%h exp=deadbeef", idex_rs_data_o); end
    fetch(32'h00003020, 32'h54);
    tick();
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    tick();
    wb_we = 1'b0;
    checks++; if (idex_rs_data_o !== 32'h0) begin failures++; $display("FAIL r0_bypass got=%h exp=00000000", idex_rs_data_o); end
    tick();
    checks++; if (idex_rt_data_o !== 32'h0) begin failures++; $display("FAIL r0_stored got=%h exp=00000000", idex_rt_data_o); end
  endtask

  task automatic test_load_use();
    fetch(32'h8C220000, 32'h20);
    tick();
    fetch(32'h00432020, 32'h24);
    #1;
    checks++; if (pc_stall_o !== 1'b0) begin failures++; $display("FAIL lu_pre_stall got=%0h exp=0", pc_stall_o); end
    tick();
    fetch(32'h0, 32'h28);
    #1;
    checks++; if (pc_stall_o !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0h exp=1", pc_stall_o); end
    checks++; if (idex_mem_rd_o !== 1'b1 || idex_dst_o !== 5'd2) begin failures++; $display("FAIL lu_lw got=%0h/%0d exp=1/2", idex_mem_rd_o, idex_dst_o); end
    tick();
    checks++; if (idex_valid_o !== 1'b0 || ctrl !== 4'b0000) begin failures++; $display("FAIL lu_bubble got=%0h/%b exp=0/0000", idex_valid_o, ctrl); end
    checks++; if (pc_stall_o !== 1'b0) begin failures++; $display("FAIL lu_stall_once got=%0h exp=0", pc_stall_o); end
    tick();
    checks++; if (idex_valid_o !== 1'b1 || idex_pc_o !== 32'h24) begin failures++; $display("FAIL lu_add got=%0h/%h exp=1/00000024", idex_valid_o, idex_pc_o); end
    checks++; if (idex_rs_o !== 5'd2 || idex_rt_o !== 5'd3 || idex_dst_o !== 5'd4) begin failures++; $display("FAIL lu_regs got=%0d/%0d/%0d exp=2/3/4", idex_rs_o, idex_rt_o, idex_dst_o); end
    checks++; if (idex_funct_o !== 6'h20) begin failures++; $display("FAIL lu_funct got=%h exp=20", idex_funct_o); end
    fetch(32'h8C200000, 32'h30);
    tick();
    fetch(32'h00032020, 32'h34);
    tick();
    checks++; if (pc_stall_o !== 1'b0) begin failures++; $display("FAIL lu_r0_stall got=%0h exp=0", pc_stall_o); end
    tick();
    checks++; if (idex_valid_o !== 1'b1 || idex_pc_o !== 32'h34) begin failures++; $display("FAIL lu_r0_flow got=%0h/%h exp=1/00000034", idex_valid_o, idex_pc_o); end
  endtask

  task automatic test_flush();
    fetch(32'h8C220000, 32'h60);
    tick();
    fetch(32'h00432020, 32'h64);
    tick();
    flush = 1'b1; wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
    fetch(32'h0, 32'h68);
    #1;
    checks++; if (pc_stall_o !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0h exp=0", pc_stall_o); end
    tick();
    flush = 1'b0; wb_we = 1'b0;
    fetch(32'h00E04020, 32'h6C);
    checks++; if (idex_valid_o !== 1'b0 || ctrl !== 4'b0000) begin failures++; $display("FAIL flush_bubble got=%0h/%b exp=0/0000", idex_valid_o, ctrl); end
    tick();
    checks++; if (idex_valid_o !== 1'b0) begin failures++; $display("FAIL flush_ifid got=%0h exp=0", idex_valid_o); end
    tick();
    checks++; if (idex_valid_o !== 1'b1 || idex_pc_o !== 32'h6C) begin failures++; $display("FAIL flush_resume got=%0h/%h exp=1/0000006c", idex_valid_o, idex_pc_o); end
    checks++; if (idex_rs_data_o !== 32'h55) begin failures++; $display("FAIL flush_wb got=%h exp=00000055", idex_rs_data_o); end
  endtask

  task automatic test_back_to_back();
    fetch(32'hACC50004, 32'h80);
    tick();
    fetch(32'h1022FFFF, 32'h84);
    tick();
    checks++; if (ctrl !== 4'b0010 || idex_dst_o !== 5'd0 || idex_imm_o !== 32'h4) begin failures++; $display("FAIL sw got=%b/%0d/%h exp=0010/0/00000004", ctrl, idex_dst_o, idex_imm_o); end
    fetch(32'hFC000000, 32'h88);
    tick();
    checks++; if (ctrl !== 4'b0001 || idex_imm_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL beq got=%b/%h exp=0001/ffffffff", ctrl, idex_imm_o); end
    fetch(32'h342900F0, 32'h8C);
    tick();
    checks++; if (ctrl !== 4'b0000 || idex_valid_o !== 1'b1 || idex_opcode_o !== 6'h3F) begin failures++; $display("FAIL unknown got=%b/%0h/%h exp=0000/1/3f", ctrl, idex_valid_o, idex_opcode_o); end
    fetch(32'h0, 32'h90);
    tick();
    checks++; if (ctrl !== 4'b1000 || idex_dst_o !== 5'd9 || idex_imm_o !== 32'hF0) begin failures++; $display("FAIL ori got=%b/%0d/%h exp=1000/9/000000f0", ctrl, idex_dst_o, idex_imm_o); end
  endtask

  task automatic test_reset_mid();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hAAAA5555;
    fetch(32'h8C220000, 32'hA0);
    tick();
    wb_we = 1'b0;
    fetch(32'h00432020, 32'hA4);
    tick();
    checks++; if (pc_stall_o !== 1'b1) begin failures++; $display("FAIL rmid_pre_stall got=%0h exp=1", pc_stall_o); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pc_stall_o !== 1'b0) begin failures++; $display("FAIL rmid_stall got=%0h exp=0", pc_stall_o); end
    checks++; if (idex_valid_o !== 1'b0 || idex_pc_o !== 32'h0 || idex_dst_o !== 5'd0 || ctrl !== 4'b0000) begin failures++; $display("FAIL rmid_idex got=%0h/%h/%0d/%b exp=0/0/0/0000", idex_valid_o, idex_pc_o, idex_dst_o, ctrl); end
    tick();
    rst = 1'b0;
    fetch(32'h00A03020, 32'hB0);
    tick();
    fetch(32'h0, 32'hB4);
    tick();
    checks++; if (idex_valid_o !== 1'b1 || idex_rs_o !== 5'd5 || idex_rs_data_o !== 32'h0) begin failures++; $display("FAIL rmid_r5 got=%0h/%0d/%h exp=1/5/00000000", idex_valid_o, idex_rs_o, idex_rs_data_o); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sign_ext();
    test_bypass();
    test_load_use();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Second stage of the 5-stage pipeline, directly downstream of instruction fetch. Captures the fetched instruction and PC in an IF/ID register and decodes it. Reads operands from a 32x32 register file with a write-back port, and presents a registered ID/EX bundle to execute. Detects load-use hazards, stalls fetch for one cycle, and honours branch flushes from execute.

## Interface
- Parameters
  - `REG_COUNT`, 32, number of architectural registers; addresses are 5 bits
  - `DATA_W`, 32, register and PC width
- Ports
  - `clk`  in  1  single clock; all state updates on the rising edge
  - `rst`  in  1  asynchronous, active-high reset
  - `if_instr_i`  in  32  instruction word from fetch
  - `if_pc_i`  in  32  PC of `if_instr_i`
  - `flush_i`  in  1  branch taken in execute; squash IF/ID and ID/EX contents
  - `wb_we_i`  in  1  write-back enable
  - `wb_addr_i`  in  5  write-back register address
  - `wb_data_i`  in  32  write-back data
  - `pc_stall_o`  out  1  combinational; fetch must hold PC this cycle
  - `idex_valid_o`  out  1  ID/EX holds a real instruction
  - `idex_pc_o`  out  32  PC of the instruction in ID/EX
  - `idex_opcode_o`  out  6  instr[31:26]
  - `idex_funct_o`  out  6  instr[5:0]
  - `idex_rs_data_o`, `idex_rt_data_o`  out  32 each  operand values
  - `idex_rs_o`, `idex_rt_o`, `idex_dst_o`  out  5 each  source and destination register addresses
  - `idex_imm_o`  out  32  sign-extended instr[15:0]
  - `idex_reg_we_o`, `idex_mem_rd_o`, `idex_mem_wr_o`, `idex_branch_o`  out  1 each  control bits

## Operation
- IF/ID register: `ifid_valid`, `ifid_pc`, `ifid_instr`.
  - Loaded every cycle unless `pc_stall_o` is asserted, in which case it holds.
  - `flush_i` clears `ifid_valid`.
- Decode acts on the IF/ID contents.
  - Opcode `OP_RTYPE` (0x00): `dst` = instr[15:11], `reg_we` = 1.
  - `OP_ADDI` (0x08), `OP_ANDI` (0x0C), `OP_ORI` (0x0D): `dst` = rt, `reg_we` = 1.
  - `OP_LW` (0x23): `dst` = rt, `reg_we` = 1, `mem_rd` = 1.
  - `OP_SW` (0x2B): `mem_wr` = 1.
  - `OP_BEQ` (0x04): `branch` = 1.
  - Any other opcode: all control bits 0, `valid` passes through unchanged.
- Register file
  - Reads are combinational.
  - R0 always reads 0, and writes to R0 are ignored.
  - Write-through bypass: when `wb_we_i` is set and `wb_addr_i` equals rs/rt (nonzero) in the same cycle, the read returns `wb_data_i`.
- Load-use hazard (`pc_stall_o`) is asserted when all of the following hold:
  - `idex_valid_o` and `idex_mem_rd_o` are set,
  - `idex_dst_o` is nonzero,
  - `ifid_valid` is set,
  - `idex_dst_o` equals decoded rs, or equals decoded rt.
- On a stall, the ID/EX register loads a bubble: `valid` = 0 and all control bits = 0. IF/ID holds.
- `flush_i` takes priority over stall.
  - ID/EX loads a bubble.
  - IF/ID valid clears.
  - `pc_stall_o` is forced to 0.
- Invalid IF/ID contents propagate as a bubble.

## Timing
- Reset: all IF/ID and ID/EX fields and all 32 registers are 0, and `pc_stall_o` = 0. Reset takes effect immediately and asynchronously, including in the middle of a stall.
- Latency:
  - `if_instr_i` sampled at edge N appears on `idex_*` after edge N+1.
  - Write-back data written at edge N is readable from edge N onward; in the same cycle it arrives through the bypass.
- A stall lasts exactly one cycle per load. The bubble clears the hazard on the next cycle.
- Simultaneous `flush_i` and write-back: the write still commits.

## Structure
- `definitions_pkg` holds:
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`, `OP_ANDI`, `OP_ORI`)
  - `REG_ADDR_W` = 5
  - the `idex_ctrl_t` packed struct (`reg_we`, `mem_rd`, `mem_wr`, `branch`)
- One sub-module: `register_file`, which contains the storage array, two read ports, one write port, the R0 rule and the bypass.
- Decode logic and hazard logic stay in the top module.

## Test plan
- Reset mid-run: assert `rst` while IF/ID holds a valid `LW` -> all `idex_*` = 0 and `pc_stall_o` = 0 with no clock edge, and R5 reads 0 afterwards.
- `ADDI R3,R0,7` (0x20030007) at PC 0x10 -> two edges later: `idex_valid_o` = 1, `idex_dst_o` = 3, `idex_imm_o` = 7, `idex_reg_we_o` = 1, `idex_pc_o` = 0x10.
- Sign extension: instr[15:0] = 0xFFFC -> `idex_imm_o` = 0xFFFFFFFC.
- Write-back bypass: `wb_we_i`=1, `wb_addr_i`=4, `wb_data_i`=0xDEADBEEF in the same cycle that IF/ID holds an R-type with rs=4 -> `idex_rs_data_o` = 0xDEADBEEF. A write of 0x1234 to R0 -> later reads of R0 return 0.
- Load-use: `LW R2,0(R1)` followed by `ADD R4,R2,R3` -> `pc_stall_o` = 1 for exactly one cycle, then one bubble in ID/EX (`valid` = 0), then the ADD arrives with `idex_rs_o` = 2. `LW` into R0 followed by a use of R0 -> no stall.
- Flush during stall: assert `flush_i` in the cycle `pc_stall_o` would be 1 -> `pc_stall_o` = 0, next ID/EX is a bubble, IF/ID `valid` = 0.
